// File: rtl/pc_next_unit.sv
// Next-PC generator for the RV32I fetch stage: holds the fetch PC and picks the next one by
// priority (trap, pending redirect, branch/JAL, JALR, PC+4), with stall capture and misalign reporting.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic [1:0]       pc_src_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic [XLEN-1:0]  jalr_target_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_vector_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  misalign_addr_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [XLEN-1:0]  FOUR    = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0]  LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    if (IALIGN == 2) return a[0];
    else             return |a[1:0];
  endfunction

  logic [XLEN-1:0]  pc_p1;
  logic             pend_valid_p1;
  logic             pend_is_trap_p1;
  logic [XLEN-1:0]  pend_addr_p1;
  logic             misalign_p1;
  logic [XLEN-1:0]  misalign_addr_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             br_req;
  logic             jalr_req;
  logic             req_any;
  logic [XLEN-1:0]  req_addr;
  logic             req_mis;
  logic             req_ok;
  logic             stall_capture;

  // Stage 0: request decode, alignment check and flush generation
  always_comb begin
    br_req        = branch_taken_i | (pc_src_i == 2'b10);
    jalr_req      = !br_req && (pc_src_i == 2'b01);
    req_any       = br_req | jalr_req;
    req_addr      = br_req ? br_target_i : (jalr_target_i & LSB_CLR);
    req_mis       = req_any && is_misaligned(req_addr);
    req_ok        = req_any && !req_mis;
    // A pending trap outranks any later branch seen during the same stall.
    stall_capture = req_ok && !(pend_valid_p1 && pend_is_trap_p1);
    flush_o       = 1'b0;
    if (!rst) begin
      if (stall_i) flush_o = trap_valid_i | stall_capture;
      else         flush_o = trap_valid_i | (!pend_valid_p1 && req_ok);
    end
  end

  assign pc_plus4_o = pc_p1 + FOUR;

  // Stage 1: PC register, pending redirect, misalign pulse and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1            <= RESET_VECTOR;
      pend_valid_p1    <= 1'b0;
      pend_is_trap_p1  <= 1'b0;
      pend_addr_p1     <= '0;
      misalign_p1      <= 1'b0;
      misalign_addr_p1 <= '0;
      cnt_p1           <= '0;
    end else begin
      misalign_p1 <= req_mis;
      if (req_mis) misalign_addr_p1 <= req_addr;
      if (stall_i) begin
        if (trap_valid_i) begin
          pend_valid_p1   <= 1'b1;
          pend_is_trap_p1 <= 1'b1;
          pend_addr_p1    <= trap_vector_i;
        end else if (stall_capture) begin
          pend_valid_p1   <= 1'b1;
          pend_is_trap_p1 <= 1'b0;
          pend_addr_p1    <= req_addr;
        end
      end else if (trap_valid_i) begin
        pc_p1           <= trap_vector_i;
        pend_valid_p1   <= 1'b0;
        pend_is_trap_p1 <= 1'b0;
        cnt_p1          <= sat_inc(cnt_p1);
      end else if (pend_valid_p1) begin
        pc_p1           <= pend_addr_p1;
        pend_valid_p1   <= 1'b0;
        pend_is_trap_p1 <= 1'b0;
        cnt_p1          <= sat_inc(cnt_p1);
      end else if (req_ok) begin
        pc_p1  <= req_addr;
        cnt_p1 <= sat_inc(cnt_p1);
      end else begin
        pc_p1 <= pc_plus4_o;
      end
    end
  end

  assign pc_o            = pc_p1;
  assign misalign_o      = misalign_p1;
  assign misalign_addr_o = misalign_addr_p1;
  assign redirect_cnt_o  = cnt_p1;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: default instance plus a 2-bit counter instance and an IALIGN=2 instance.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] jalr_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;

  logic [31:0] pc, pc4, mis_addr;
  logic        flush, mis;
  logic [15:0] cnt;
  logic [31:0] pc_b, pc4_b, mis_addr_b;
  logic        flush_b, mis_b;
  logic [1:0]  cnt_b;
  logic [31:0] pc_c, pc4_c, mis_addr_c;
  logic        flush_c, mis_c;
  logic [15:0] cnt_c;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_src_i(pc_src), .branch_taken_i(branch_taken),
    .br_target_i(br_target), .jalr_target_i(jalr_target), .trap_valid_i(trap_valid),
    .trap_vector_i(trap_vector), .pc_o(pc), .pc_plus4_o(pc4), .flush_o(flush),
    .misalign_o(mis), .misalign_addr_o(mis_addr), .redirect_cnt_o(cnt));

  pc_next_unit #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_src_i(pc_src), .branch_taken_i(branch_taken),
    .br_target_i(br_target), .jalr_target_i(jalr_target), .trap_valid_i(trap_valid),
    .trap_vector_i(trap_vector), .pc_o(pc_b), .pc_plus4_o(pc4_b), .flush_o(flush_b),
    .misalign_o(mis_b), .misalign_addr_o(mis_addr_b), .redirect_cnt_o(cnt_b));

  pc_next_unit #(.IALIGN(2)) dut_c (
    .clk(clk), .rst(rst), .stall_i(stall), .pc_src_i(pc_src), .branch_taken_i(branch_taken),
    .br_target_i(br_target), .jalr_target_i(jalr_target), .trap_valid_i(trap_valid),
    .trap_vector_i(trap_vector), .pc_o(pc_c), .pc_plus4_o(pc4_c), .flush_o(flush_c),
    .misalign_o(mis_c), .misalign_addr_o(mis_addr_c), .redirect_cnt_o(cnt_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; trap_valid = 1'b1; trap_vector = 32'h500;
    tick;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    vectors++; if (mis !== 1'b0 || mis_addr !== 32'h0) begin errors++; $display("FAIL reset_misalign got=%b/%h exp=0/0", mis, mis_addr); end
    vectors++; if (pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got=%h exp=4", pc4); end
    rst = 1'b0; trap_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL free_flush[%0d] got=%b exp=0", i, flush); end
      tick;
      vectors++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL free_pc[%0d] got=%h exp=%h", i, pc, 32'(4 * i)); end
      vectors++; if (cnt !== 16'd0) begin errors++; $display("FAIL free_cnt[%0d] got=%0d exp=0", i, cnt); end
    end
  endtask

  task automatic test_branch;
    tick;
    vectors++; if (pc !== 32'h10) begin errors++; $display("FAIL br_start_pc got=%h exp=10", pc); end
    pc_src = 2'b10; br_target = 32'h40; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL br_src_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h40 || cnt !== 16'd1) begin errors++; $display("FAIL br_src pc=%h cnt=%0d exp=40/1", pc, cnt); end
    pc_src = 2'b00; branch_taken = 1'b1; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL br_taken_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h40 || cnt !== 16'd2) begin errors++; $display("FAIL br_taken pc=%h cnt=%0d exp=40/2", pc, cnt); end
    branch_taken = 1'b0; pc_src = 2'b11; #1;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL src11_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h44 || cnt !== 16'd2) begin errors++; $display("FAIL src11 pc=%h cnt=%0d exp=44/2", pc, cnt); end
    pc_src = 2'b00;
  endtask

  task automatic test_jalr_misalign;
    pc_src = 2'b01; jalr_target = 32'h101; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h100 || cnt !== 16'd3) begin errors++; $display("FAIL jalr pc=%h cnt=%0d exp=100/3", pc, cnt); end
    vectors++; if (pc_c !== 32'h100) begin errors++; $display("FAIL jalr_ialign2 pc=%h exp=100", pc_c); end
    pc_src = 2'b10; br_target = 32'h102; #1;
    vectors++; if (flush !== 1'b0 || flush_c !== 1'b1) begin errors++; $display("FAIL mis_flush got=%b/%b exp=0/1", flush, flush_c); end
    tick;
    vectors++; if (pc !== 32'h104 || cnt !== 16'd3) begin errors++; $display("FAIL mis_pc pc=%h cnt=%0d exp=104/3", pc, cnt); end
    vectors++; if (mis !== 1'b1 || mis_addr !== 32'h102) begin errors++; $display("FAIL mis_pulse got=%b/%h exp=1/102", mis, mis_addr); end
    vectors++; if (pc_c !== 32'h102 || mis_c !== 1'b0) begin errors++; $display("FAIL mis_ialign2 pc=%h mis=%b exp=102/0", pc_c, mis_c); end
    pc_src = 2'b00;
    tick;
    vectors++; if (pc !== 32'h108 || mis !== 1'b0) begin errors++; $display("FAIL mis_end pc=%h mis=%b exp=108/0", pc, mis); end
    pc_src = 2'b01; branch_taken = 1'b1; br_target = 32'h300; jalr_target = 32'h500; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h300 || cnt !== 16'd4) begin errors++; $display("FAIL prio pc=%h cnt=%0d exp=300/4", pc, cnt); end
    pc_src = 2'b00; branch_taken = 1'b0;
  endtask

  task automatic test_stall;
    stall = 1'b1; pc_src = 2'b10; br_target = 32'h80; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_br_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h300 || cnt !== 16'd4) begin errors++; $display("FAIL stall_hold1 pc=%h cnt=%0d exp=300/4", pc, cnt); end
    pc_src = 2'b00; trap_valid = 1'b1; trap_vector = 32'h200; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_trap_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h300) begin errors++; $display("FAIL stall_hold2 pc=%h exp=300", pc); end
    trap_valid = 1'b0; pc_src = 2'b10; br_target = 32'h90; #1;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_br_after_trap_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h300) begin errors++; $display("FAIL stall_hold3 pc=%h exp=300", pc); end
    stall = 1'b0; pc_src = 2'b00; #1;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL release_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h200 || cnt !== 16'd5) begin errors++; $display("FAIL release pc=%h cnt=%0d exp=200/5", pc, cnt); end
    tick;
    vectors++; if (pc !== 32'h204) begin errors++; $display("FAIL release_next pc=%h exp=204", pc); end
  endtask

  task automatic test_back_to_back;
    stall = 1'b1; pc_src = 2'b10; br_target = 32'h80;
    tick;
    stall = 1'b0; br_target = 32'h90; #1;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h80 || cnt !== 16'd6) begin errors++; $display("FAIL b2b_pend pc=%h cnt=%0d exp=80/6", pc, cnt); end
    pc_src = 2'b00;
    tick;
    vectors++; if (pc !== 32'h84) begin errors++; $display("FAIL b2b_next pc=%h exp=84", pc); end
    stall = 1'b1; pc_src = 2'b10; br_target = 32'h80;
    tick;
    stall = 1'b0; pc_src = 2'b00; trap_valid = 1'b1; trap_vector = 32'h400; #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL trap_wins_flush got=%b exp=1", flush); end
    tick;
    vectors++; if (pc !== 32'h400 || cnt !== 16'd7) begin errors++; $display("FAIL trap_wins pc=%h cnt=%0d exp=400/7", pc, cnt); end
    trap_valid = 1'b0;
    tick;
    vectors++; if (pc !== 32'h404 || cnt !== 16'd7) begin errors++; $display("FAIL pend_cleared pc=%h cnt=%0d exp=404/7", pc, cnt); end
    trap_valid = 1'b1; trap_vector = 32'h203;
    tick;
    vectors++; if (pc !== 32'h203 || cnt !== 16'd8) begin errors++; $display("FAIL trap_odd pc=%h cnt=%0d exp=203/8", pc, cnt); end
    trap_valid = 1'b0;
    tick;
    vectors++; if (mis !== 1'b0 || pc !== 32'h207) begin errors++; $display("FAIL trap_nocheck mis=%b pc=%h exp=0/207", mis, pc); end
  endtask

  task automatic test_reset_mid_stall;
    stall = 1'b1; pc_src = 2'b10; br_target = 32'hA0;
    tick;
    vectors++; if (pc !== 32'h207) begin errors++; $display("FAIL rms_hold pc=%h exp=207", pc); end
    rst = 1'b1; pc_src = 2'b00;
    tick;
    vectors++; if (pc !== 32'h0 || cnt !== 16'd0) begin errors++; $display("FAIL rms_reset pc=%h cnt=%0d exp=0/0", pc, cnt); end
    rst = 1'b0; stall = 1'b0; #1;
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL rms_flush got=%b exp=0", flush); end
    tick;
    vectors++; if (pc !== 32'h4 || cnt !== 16'd0) begin errors++; $display("FAIL rms_release pc=%h cnt=%0d exp=4/0", pc, cnt); end
    tick;
    vectors++; if (pc !== 32'h8) begin errors++; $display("FAIL rms_next pc=%h exp=8", pc); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pc_src = 2'b10; br_target = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++; if (cnt_b !== exp_b[i]) begin errors++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, cnt_b, exp_b[i]); end
      vectors++; if (cnt !== 16'(i + 1) || pc !== 32'h40) begin errors++; $display("FAIL sat_cnt16[%0d] cnt=%0d pc=%h exp=%0d/40", i, cnt, pc, i + 1); end
    end
    pc_src = 2'b00;
  endtask

  task automatic test_wrap;
    pc_src = 2'b10; br_target = 32'hFFFF_FFFC;
    tick;
    vectors++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 pc=%h pc4=%h exp=fffffffc/0", pc, pc4); end
    pc_src = 2'b00;
    tick;
    vectors++; if (pc !== 32'h0 || cnt !== 16'd6) begin errors++; $display("FAIL wrap_pc pc=%h cnt=%0d exp=0/6", pc, cnt); end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_jalr_misalign;
    test_stall;
    test_back_to_back;
    test_reset_mid_stall;
    test_saturation;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised next-PC generator for the RV32I fetch stage; replaces the fixed 3-input PC-source mux.
- Holds the architectural fetch PC register and selects the next PC by priority: trap, redirect pending from a stall, branch/JAL, JALR, PC+4.
- Adds stall handling with redirect capture, JALR LSB clearing, misaligned-target detection and a saturating redirect counter.
- Sits between EX (redirect sources) and IF (instruction memory address).

Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 4, instruction alignment in bytes; legal values are 4 and 2.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  IF stall; PC holds while high.
- pc_src_i  in  2  00 = PC+4, 01 = JALR, 10 = branch/JAL target, 11 = PC+4.
- branch_taken_i  in  1  resolved taken branch; forces the target path.
- br_target_i  in  XLEN  branch/JAL target from EX.
- jalr_target_i  in  XLEN  rs1+imm from EX; not yet LSB-cleared.
- trap_valid_i  in  1  trap redirect request (single-cycle pulse).
- trap_vector_i  in  XLEN  trap handler address.
- pc_o  out  XLEN  current fetch PC (register output).
- pc_plus4_o  out  XLEN  pc_o + 4, combinational.
- flush_o  out  1  redirect accepted this cycle; flushes IF/ID.
- misalign_o  out  1  registered one-cycle pulse: rejected misaligned target.
- misalign_addr_o  out  XLEN  offending target, registered with misalign_o.
- redirect_cnt_o  out  CNT_W  saturating count of applied redirects.

Behaviour:
- Reset (rst=1 at posedge):
  - pc_o = RESET_VECTOR.
  - pend_valid = 0, pend_addr = 0, pend_is_trap = 0.
  - misalign_o = 0, misalign_addr_o = 0, redirect_cnt_o = 0.
  - flush_o is combinational but forced to 0 while rst=1.
  - Reset mid-stall discards any pending redirect.
- Request decode (combinational):
  - br_req = branch_taken_i | (pc_src_i == 10); addr = br_target_i.
  - jalr_req = !br_req & (pc_src_i == 01); addr = jalr_target_i with bit 0 cleared.
  - Otherwise no redirect (PC+4).
- Misalignment check:
  - Applies to br_req/jalr_req only; traps are never checked.
  - IALIGN=4: addr[1:0] != 0 is misaligned. IALIGN=2: addr[0] != 0 is misaligned (a JALR target never is).
  - A misaligned request is dropped: no flush, no pending capture, PC follows the non-redirect path.
  - Next cycle: misalign_o = 1 and misalign_addr_o = addr, for exactly one cycle.
- Next-PC priority (a lower item applies only if no higher item is active):
  1. trap_valid_i: trap_vector_i.
  2. pend_valid: pend_addr.
  3. Aligned br_req/jalr_req: the redirect address.
  4. Otherwise pc_o + 4.
- Stall:
  - stall_i=1: pc_o holds.
  - A new trap captures into pend (overwrites any pending entry; pend_is_trap = 1).
  - A new aligned br/jalr captures into pend only if there is no pending trap.
  - flush_o = 1 for any captured request.
- Stall release (stall_i=0 with pend_valid=1):
  - pc_o <= pend_addr and pend_valid <= 0.
  - A new trap in the same cycle wins instead; pend is cleared.
  - A new br/jalr in the same cycle is ignored, since the pending entry is older.
- Non-stalled flush: flush_o = 1 whenever priority item 1 or 3 is taken.
- Counter: increments by 1 on each posedge where pc_o is loaded from a trap, pend or a redirect. Saturates at 2^CNT_W-1; never wraps.
- Arithmetic: PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
- Latency: a redirect presented in cycle N appears on pc_o in cycle N+1 when not stalled.

Test Plan:
- Reset then 3 free-running cycles, no requests -> pc_o = 0, 4, 8, 12; flush_o = 0; redirect_cnt_o = 0.
- At pc_o=0x10: pc_src_i=10, br_target_i=0x40 -> flush_o=1; next pc_o=0x40; redirect_cnt_o=1. Repeat with pc_src_i=00, branch_taken_i=1 -> same result.
- pc_src_i=01, jalr_target_i=0x101 -> next pc_o=0x100. Then br_target_i=0x102 with IALIGN=4 -> pc_o advances by 4; misalign_o pulses for 1 cycle with misalign_addr_o=0x102.
- Hold stall_i=1 for 3 cycles:
  - cycle 1: branch to 0x80 -> pc_o holds; flush_o=1.
  - cycle 2: trap to 0x200 -> pending entry overwritten.
  - release stall -> pc_o=0x200 on the next edge, then 0x204.
- Release stall with pend=0x80 while br_target=0x90 is also requested -> pc_o=0x80. Assert rst during a stall with a pending entry -> pc_o=RESET_VECTOR, and no redirect is applied after release.
- Set CNT_W=2 and apply 5 redirects -> redirect_cnt_o = 1, 2, 3, 3, 3.
